ovc_alloc_list: RTL and testbench

Stateful successor to the combinational output-VC list. It tracks, per output port, which output VCs are free and how many downstream credits each holds. It applies message-class masking to that state and grants one eligible output VC per cycle using round-robin selection. It sits between the VC allocator request path and the output-port credit logic.

---
 rtl/ovc_alloc_list.sv | 171 +++++++++++++++++
 tb/tb_ovc_alloc_list.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovc_alloc_list.sv
// ovc_alloc_list
//   Stateful output-VC allocation list for one output port. It tracks which
//   output VCs are free and how many downstream credits each holds. It masks
//   the eligible set by message class and grants one eligible VC per cycle in
//   round-robin order.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   req          allocation request this cycle
//   class_in     message class of the request
//   ovc_release  one-hot-or-zero; tail flit of that VC sent, VC becomes free
//   credit_in    per-VC credit return (+1)
//   flit_sent    per-VC flit forwarded downstream (-1)
//   ovcs_avail   eligible VCs for class_in (combinational)
//   grant        one-hot granted VC, zero if none (combinational)
//   grant_valid  |grant
//   ovc_free     registered free flags
//   credit_cnt   registered credit counters, VC i at [i*BW +: BW]
//   err          sticky: [0] credit overflow, [1] credit underflow,
//                [2] illegal class or release of an already-free VC
module ovc_alloc_list #(
    parameter int    V                                      = 4,
    parameter int    C                                      = 2,
    parameter logic [((C > 1) ? C : 1)*V-1:0] CLASS_SETTING = '1,
    parameter int    B                                      = 4,
    parameter string REALLOC_MODE                           = "NONATOMIC",
    localparam int   CW = (C > 2) ? $clog2(C) : 1,
    localparam int   BW = $clog2(B + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [CW-1:0] class_in,
    input  logic [V-1:0]  ovc_release,
    input  logic [V-1:0]  credit_in,
    input  logic [V-1:0]  flit_sent,
    output logic [V-1:0]  ovcs_avail,
    output logic [V-1:0]  grant,
    output logic          grant_valid,
    output logic [V-1:0]  ovc_free,
    output logic [V*BW-1:0] credit_cnt,
    output logic [2:0]    err
);

    localparam int            PW     = $clog2(V);
    localparam logic [BW-1:0] B_VAL  = BW'(B);
    localparam bit            ATOMIC = (REALLOC_MODE == "ATOMIC");

    logic [V-1:0]          ovc_free_q, ovc_free_d;
    logic [V-1:0][BW-1:0]  credit_q, credit_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [2:0]            err_q, err_d;

    logic [V-1:0]  class_mask;
    logic          class_illegal;
    logic [V-1:0]  elig;
    logic          grant_found;
    logic [PW-1:0] grant_idx;

    // Class mask lookup; an out-of-range class matches no entry and so
    // yields an empty mask.
    always_comb begin
        class_mask    = '0;
        class_illegal = 1'b0;
        if (C <= 1) begin
            class_mask = '1;
        end else begin
            class_illegal = 1'b1;
            for (int c = 0; c < C; c++) begin
                if (class_in == CW'(c)) begin
                    class_mask    = CLASS_SETTING[c*V +: V];
                    class_illegal = 1'b0;
                end
            end
        end
    end

    // ATOMIC reallocation waits until the downstream buffer is fully drained.
    always_comb begin
        elig = '0;
        for (int i = 0; i < V; i++) begin
            if (ATOMIC) begin
                elig[i] = ovc_free_q[i] & class_mask[i] & (credit_q[i] == B_VAL);
            end else begin
                elig[i] = ovc_free_q[i] & class_mask[i] & (credit_q[i] != '0);
            end
        end
    end

    // Round-robin scan starting at ptr_q; the first eligible hit wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < V; k++) begin
            if (!grant_found && elig[(int'(ptr_q) + k) % V]) begin
                grant_found = 1'b1;
                grant_idx   = PW'((int'(ptr_q) + k) % V);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (req && grant_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Release is applied after the grant so that releasing a VC that is
    // still free (an error) leaves it free even if it was granted too.
    always_comb begin
        ovc_free_d = ovc_free_q;
        credit_d   = credit_q;
        ptr_d      = ptr_q;
        err_d      = err_q;

        if (grant_valid) begin
            ovc_free_d[grant_idx] = 1'b0;
            ptr_d = (grant_idx == PW'(V - 1)) ? '0 : grant_idx + PW'(1);
        end

        if (req && class_illegal) begin
            err_d[2] = 1'b1;
        end

        for (int i = 0; i < V; i++) begin
            if (ovc_release[i]) begin
                if (ovc_free_q[i]) begin
                    err_d[2] = 1'b1;
                end
                ovc_free_d[i] = 1'b1;
            end

            if (credit_in[i] && !flit_sent[i]) begin
                if (credit_q[i] == B_VAL) begin
                    err_d[0] = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + BW'(1);
                end
            end else if (flit_sent[i] && !credit_in[i]) begin
                if (credit_q[i] == '0) begin
                    err_d[1] = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] - BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovc_free_q <= '1;
            credit_q   <= {V{B_VAL}};
            ptr_q      <= '0;
            err_q      <= '0;
        end else begin
            ovc_free_q <= ovc_free_d;
            credit_q   <= credit_d;
            ptr_q      <= ptr_d;
            err_q      <= err_d;
        end
    end

    assign ovcs_avail  = elig;
    assign grant_valid = |grant;
    assign ovc_free    = ovc_free_q;
    assign credit_cnt  = credit_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ovc_alloc_list.sv
// tb_ovc_alloc_list
//   Self-checking bench for ovc_alloc_list. Two instances share the stimulus:
//   a NONATOMIC one with three classes (so class 3 is out of range) and an
//   ATOMIC one with no class masking. A behavioural model tracks whichever
//   instance is selected; expected results are queued when stimulus is driven
//   and popped when the instance produces them.
module tb_ovc_alloc_list;

    localparam int V  = 4;
    localparam int B  = 4;
    localparam int BW = 3;

    logic        clk;
    logic        reset;
    logic        req;
    logic [1:0]  class_in;
    logic [0:0]  class_a;
    logic [3:0]  ovc_release, credit_in, flit_sent;

    logic [3:0]  avail_n, grant_n, free_n, avail_a, grant_a, free_a;
    logic        gvalid_n, gvalid_a;
    logic [11:0] cred_n, cred_a;
    logic [2:0]  err_n, err_a;

    logic        sel_a;
    logic [3:0]  obs_avail, obs_grant, obs_free;
    logic        obs_gvalid;
    logic [11:0] obs_cred;
    logic [2:0]  obs_err;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit          m_atomic;
    int          m_nclass;
    logic [11:0] m_set;
    logic [3:0]  m_free;
    int          m_cred [4];
    int          m_ptr;
    logic [2:0]  m_err;

    typedef struct {
        logic [3:0]  avail;
        logic [3:0]  grant;
        logic [3:0]  free;
        logic [11:0] cred;
        logic [2:0]  err;
    } exp_t;
    exp_t exp_q[$];

    assign class_a = class_in[0:0];

    ovc_alloc_list #(
        .V(V), .C(3), .CLASS_SETTING(12'b1111_1100_0011), .B(B), .REALLOC_MODE("NONATOMIC")
    ) dut_n (
        .clk(clk), .reset(reset), .req(req), .class_in(class_in),
        .ovc_release(ovc_release), .credit_in(credit_in), .flit_sent(flit_sent),
        .ovcs_avail(avail_n), .grant(grant_n), .grant_valid(gvalid_n),
        .ovc_free(free_n), .credit_cnt(cred_n), .err(err_n)
    );

    ovc_alloc_list #(
        .V(V), .C(1), .CLASS_SETTING(4'b1111), .B(B), .REALLOC_MODE("ATOMIC")
    ) dut_a (
        .clk(clk), .reset(reset), .req(req), .class_in(class_a),
        .ovc_release(ovc_release), .credit_in(credit_in), .flit_sent(flit_sent),
        .ovcs_avail(avail_a), .grant(grant_a), .grant_valid(gvalid_a),
        .ovc_free(free_a), .credit_cnt(cred_a), .err(err_a)
    );

    assign obs_avail  = sel_a ? avail_a  : avail_n;
    assign obs_grant  = sel_a ? grant_a  : grant_n;
    assign obs_gvalid = sel_a ? gvalid_a : gvalid_n;
    assign obs_free   = sel_a ? free_a   : free_n;
    assign obs_cred   = sel_a ? cred_a   : cred_n;
    assign obs_err    = sel_a ? err_a    : err_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [3:0] modelMask(input logic [1:0] cls);
        logic [3:0] m;
        if (m_nclass <= 1)          m = 4'hF;
        else if (int'(cls) >= m_nclass) m = 4'h0;
        else                        m = m_set[int'(cls)*4 +: 4];
        return m;
    endfunction

    function automatic logic [3:0] modelElig(input logic [1:0] cls);
        logic [3:0] mask;
        logic [3:0] e;
        mask = modelMask(cls);
        for (int i = 0; i < V; i++) begin
            e[i] = m_free[i] && mask[i] && (m_atomic ? (m_cred[i] == B) : (m_cred[i] > 0));
        end
        return e;
    endfunction

    function automatic logic [11:0] modelCred();
        logic [11:0] p;
        for (int i = 0; i < V; i++) p[i*BW +: BW] = 3'(m_cred[i]);
        return p;
    endfunction

    task automatic modelReset();
        m_free = 4'hF;
        for (int i = 0; i < V; i++) m_cred[i] = B;
        m_ptr = 0;
        m_err = 3'b000;
    endtask

    task automatic setMode(input bit atomic);
        sel_a    = atomic;
        m_atomic = atomic;
        m_nclass = atomic ? 1 : 3;
        m_set    = atomic ? 12'hFFF : 12'b1111_1100_0011;
    endtask

    // Holds reset for a cycle, checks the reset state, releases reset
    // one time unit after a rising edge.
    task automatic resetDut();
        req = 1'b0; class_in = 2'd0;
        ovc_release = 4'h0; credit_in = 4'h0; flit_sent = 4'h0;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("rst_free",  obs_free,  4'hF);
        checkOutput("rst_cred",  obs_cred,  12'h924);
        checkOutput("rst_err",   obs_err,   3'b000);
        checkOutput("rst_avail", obs_avail, modelElig(2'd0));
        checkOutput("rst_grant", obs_grant, 4'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock of stimulus: the model computes the combinational outputs
    // and the post-edge state; both are queued and checked in turn.
    task automatic applyStimulus(input logic r, input logic [1:0] cls,
                                 input logic [3:0] rel, input logic [3:0] cin,
                                 input logic [3:0] fs);
        exp_t e;
        logic [3:0] el;
        logic [3:0] nfree;
        int g;
        req = r; class_in = cls; ovc_release = rel; credit_in = cin; flit_sent = fs;

        el = modelElig(cls);
        g  = -1;
        for (int k = 0; k < V; k++) begin
            if (g < 0 && el[(m_ptr + k) % V]) g = (m_ptr + k) % V;
        end
        e.avail = el;
        e.grant = (r && g >= 0) ? 4'(1 << g) : 4'h0;

        nfree = m_free;
        if (r && g >= 0) begin
            nfree[g] = 1'b0;
            m_ptr    = (g + 1) % V;
        end
        if (r && m_nclass > 1 && int'(cls) >= m_nclass) m_err[2] = 1'b1;
        for (int i = 0; i < V; i++) begin
            if (rel[i]) begin
                if (m_free[i]) m_err[2] = 1'b1;
                nfree[i] = 1'b1;
            end
            if (cin[i] && !fs[i]) begin
                if (m_cred[i] == B) m_err[0] = 1'b1;
                else                m_cred[i]++;
            end else if (fs[i] && !cin[i]) begin
                if (m_cred[i] == 0) m_err[1] = 1'b1;
                else                m_cred[i]--;
            end
        end
        m_free = nfree;
        e.free = m_free;
        e.cred = modelCred();
        e.err  = m_err;
        exp_q.push_back(e);

        #1;
        checkOutput("avail",  obs_avail,  exp_q[0].avail);
        checkOutput("grant",  obs_grant,  exp_q[0].grant);
        checkOutput("gvalid", obs_gvalid, |exp_q[0].grant);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checkOutput("free", obs_free, e.free);
        checkOutput("cred", obs_cred, e.cred);
        checkOutput("err",  obs_err,  e.err);
    endtask

    initial begin
        reset = 1'b1;
        setMode(1'b0);

        // Class 0 may only use VCs 0 and 1: two grants, then nothing.
        resetDut();
        for (int n = 0; n < 4; n++) applyStimulus(1'b1, 2'd0, 4'h0, 4'h0, 4'h0);
        checkOutput("class0_free", obs_free, 4'b1100);

        // Round-robin with each granted VC released one cycle later.
        resetDut();
        applyStimulus(1'b1, 2'd2, 4'h0, 4'h0, 4'h0);
        applyStimulus(1'b1, 2'd2, 4'b0001, 4'h0, 4'h0);
        applyStimulus(1'b1, 2'd2, 4'b0010, 4'h0, 4'h0);
        applyStimulus(1'b0, 2'd2, 4'b0100, 4'h0, 4'h0);
        applyStimulus(1'b1, 2'd2, 4'h0, 4'h0, 4'h0);
        checkOutput("rr_last_grant_free", obs_free, 4'b0111);

        // Credit boundaries: overflow, underflow, simultaneous in/out, and a
        // grant combined with a flit on the same VC.
        resetDut();
        applyStimulus(1'b0, 2'd0, 4'h0, 4'b0010, 4'h0);
        for (int n = 0; n < 5; n++) applyStimulus(1'b0, 2'd0, 4'h0, 4'h0, 4'b0100);
        checkOutput("underflow_err", obs_err, 3'b011);
        applyStimulus(1'b0, 2'd0, 4'h0, 4'b1000, 4'b1000);
        applyStimulus(1'b1, 2'd2, 4'h0, 4'h0, 4'b0001);

        // Illegal class, then release of an already-free VC.
        resetDut();
        applyStimulus(1'b1, 2'd3, 4'h0, 4'h0, 4'h0);
        checkOutput("bad_class_err", obs_err, 3'b100);
        resetDut();
        applyStimulus(1'b0, 2'd0, 4'b0001, 4'h0, 4'h0);
        checkOutput("bad_release_free", obs_free, 4'hF);

        // Async reset while all VCs are allocated and ptr is non-zero.
        resetDut();
        applyStimulus(1'b1, 2'd1, 4'h0, 4'h0, 4'h0);
        for (int n = 0; n < 3; n++) applyStimulus(1'b1, 2'd2, 4'h0, 4'h0, 4'h0);
        checkOutput("pre_rst_free", obs_free, 4'h0);
        req = 1'b1; class_in = 2'd2; flit_sent = 4'b0001;
        #3;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async_free", obs_free, 4'hF);
        checkOutput("async_cred", obs_cred, 12'h924);
        checkOutput("async_err",  obs_err,  3'b000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 2'd2, 4'h0, 4'h0, 4'h0);

        // ATOMIC: a released VC is not eligible until its credits are full.
        setMode(1'b1);
        resetDut();
        applyStimulus(1'b1, 2'd0, 4'h0, 4'h0, 4'h0);
        applyStimulus(1'b0, 2'd0, 4'h0, 4'h0, 4'b0001);
        applyStimulus(1'b0, 2'd0, 4'b0001, 4'h0, 4'h0);
        applyStimulus(1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
        checkOutput("atomic_blocked", obs_avail, 4'b1110);
        applyStimulus(1'b0, 2'd0, 4'h0, 4'b0001, 4'h0);
        checkOutput("atomic_restored", obs_avail, 4'b1111);
        applyStimulus(1'b1, 2'd0, 4'h0, 4'h0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
